// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus single-cycle MTHI/MTLO.
// Optional op 111 = MADD (accumulate signed product into HI:LO) when MULDIV_MADD_EN is defined.
module muldiv_unit #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_valid,
  input  logic [2:0]  EX_MulDivOp,
  input  logic [31:0] EX_Operand_A,
  input  logic [31:0] EX_Operand_B,
  input  logic        EX_Flush,
  output logic        MulDiv_Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        MulDiv_Done
);
  // state | meaning
  // IDLE  | waiting; accepts mul/div start and MTHI/MTLO writes
  // MUL   | product settling for MUL_CYCLES cycles
  // DIV   | one restoring-division step per cycle
  // DONE  | HI/LO just written; Done pulse, back to IDLE
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
`ifdef MULDIV_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b111;
`endif
  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
  logic        sgn_q, sgn_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
`ifdef MULDIV_MADD_EN
  logic        madd_q, madd_d;
  logic [63:0] acc;
`endif

  logic        live, is_mul, is_div, start, div_signed;
  logic [63:0] mul_a, mul_b, prod;
  logic [32:0] rem_sh, trial;
  logic [31:0] quo_step, rem_step, quo_fix, rem_fix;

  // rst_n gating keeps the stall low while reset is held with a live EX instruction
  assign live = rst_n & EX_valid & ~EX_Flush & (state_q == IDLE);

  always_comb begin
    is_mul = (EX_MulDivOp == OP_MULT) | (EX_MulDivOp == OP_MULTU);
`ifdef MULDIV_MADD_EN
    is_mul = is_mul | (EX_MulDivOp == OP_MADD);
`endif
    is_div = (EX_MulDivOp == OP_DIV) | (EX_MulDivOp == OP_DIVU);
  end

  assign start      = live & (is_mul | is_div);
  assign div_signed = (EX_MulDivOp == OP_DIV);

  assign mul_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = mul_a * mul_b;
`ifdef MULDIV_MADD_EN
  assign acc   = {hi_q, lo_q} + prod;
`endif

  // a_q doubles as the dividend/quotient shift register during DIV
  assign rem_sh   = {rem_q, a_q[31]};
  assign trial    = rem_sh - {1'b0, b_q};
  assign quo_step = {a_q[30:0], ~trial[32]};
  assign rem_step = trial[32] ? rem_sh[31:0] : trial[31:0];
  assign quo_fix  = neg_quo_q ? -quo_step : quo_step;
  assign rem_fix  = neg_rem_q ? -rem_step : rem_step;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    sgn_d     = sgn_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`ifdef MULDIV_MADD_EN
    madd_d    = madd_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && is_mul) begin
          a_d     = EX_Operand_A;
          b_d     = EX_Operand_B;
          sgn_d   = (EX_MulDivOp != OP_MULTU);
          cnt_d   = '0;
          state_d = MUL;
`ifdef MULDIV_MADD_EN
          madd_d  = (EX_MulDivOp == OP_MADD);
`endif
        end else if (start && (EX_Operand_B == '0)) begin
          hi_d    = EX_Operand_A;
          lo_d    = '1;
          state_d = DONE;
        end else if (start) begin
          a_d       = (div_signed & EX_Operand_A[31]) ? -EX_Operand_A : EX_Operand_A;
          b_d       = (div_signed & EX_Operand_B[31]) ? -EX_Operand_B : EX_Operand_B;
          rem_d     = '0;
          neg_quo_d = div_signed & (EX_Operand_A[31] ^ EX_Operand_B[31]);
          neg_rem_d = div_signed & EX_Operand_A[31];
          cnt_d     = '0;
          state_d   = DIV;
        end else if (live && (EX_MulDivOp == OP_MTHI)) begin
          hi_d = EX_Operand_A;
        end else if (live && (EX_MulDivOp == OP_MTLO)) begin
          lo_d = EX_Operand_A;
        end
      end
      MUL: begin
        cnt_d = cnt_q + 6'd1;
        if (EX_Flush) begin
          state_d = IDLE;
        end else if (cnt_q == MUL_LAST) begin
`ifdef MULDIV_MADD_EN
          {hi_d, lo_d} = madd_q ? acc : prod;
`else
          {hi_d, lo_d} = prod;
`endif
          state_d = DONE;
        end
      end
      DIV: begin
        if (EX_Flush) begin
          state_d = IDLE;
        end else begin
          a_d   = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == DIV_LAST) begin
            lo_d    = quo_fix;
            hi_d    = rem_fix;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`ifdef MULDIV_MADD_EN
      madd_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      sgn_q     <= sgn_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`ifdef MULDIV_MADD_EN
      madd_q    <= madd_d;
`endif
    end
  end

  assign MulDiv_Stall = start | (((state_q == MUL) | (state_q == DIV)) & ~EX_Flush);
  assign MulDiv_Done  = (state_q == DONE);
  assign HI           = hi_q;
  assign LO           = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: an arithmetic reference model queues expected HI:LO
// per multi-cycle op; a monitor pops and compares on every Done pulse.
module tb_muldiv_unit;
  localparam int MUL_CYCLES = 2;
  localparam int DIV_CYCLES = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;
  logic        stall, done;
  logic [31:0] hi, lo;

  muldiv_unit #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .EX_valid(ex_valid), .EX_MulDivOp(op),
    .EX_Operand_A(opa), .EX_Operand_B(opb), .EX_Flush(ex_flush),
    .MulDiv_Stall(stall), .HI(hi), .LO(lo), .MulDiv_Done(done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endfunction

  // Reference model: architectural effect of one instruction on HI:LO.
  task automatic model(input bit v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int st, output bit dn);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    st = 0;
    dn = 1'b0;
    if (v) begin
      case (o)
        3'd1: begin p = sa * sb; {m_hi, m_lo} = p; st = MUL_CYCLES + 1; dn = 1'b1; end
        3'd2: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; st = MUL_CYCLES + 1; dn = 1'b1; end
        3'd3, 3'd4: begin
          dn = 1'b1;
          if (b == 32'd0) begin
            m_hi = a; m_lo = 32'hFFFFFFFF; st = 1;
          end else if (o == 3'd3) begin
            q = sa / sb; r = sa % sb;
            m_lo = q[31:0]; m_hi = r[31:0]; st = DIV_CYCLES + 1;
          end else begin
            m_lo = a / b; m_hi = a % b; st = DIV_CYCLES + 1;
          end
        end
        3'd5: m_hi = a;
        3'd6: m_lo = a;
`ifdef MULDIV_MADD_EN
        3'd7: begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + p; st = MUL_CYCLES + 1; dn = 1'b1; end
`endif
        default: ;
      endcase
    end
    if (dn) exp_q.push_back({m_hi, m_lo});
  endtask

  // Hold the instruction in EX while stalled, like the pipeline would.
  task automatic issue(input bit v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit wiggle);
    int st_exp, st_got, dn_got, cyc;
    bit dn_exp, busy;
    st_got = 0; dn_got = 0; cyc = 0; busy = 1'b1;
    @(negedge clk);
    ex_valid = v; op = o; opa = a; opb = b;
    model(v, o, a, b, st_exp, dn_exp);
    #1;
    while (busy) begin
      if (stall) st_got++;
      if (done) dn_got++;
      if (!stall) begin
        busy = 1'b0;
      end else begin
        cyc++;
        if (cyc > 64) begin
          n_cmp++; n_fail++;
          $display("FAIL stall_bound: stall still high after %0d cycles, required release", cyc);
          busy = 1'b0;
        end else begin
          @(posedge clk); #1;
          if (wiggle) begin opa = $urandom; opb = $urandom; end
          @(negedge clk); #1;
        end
      end
    end
    @(posedge clk); #1;
    ex_valid = 1'b0; op = 3'd0;
    #1;
    check("stall_cycles", 64'(st_got), 64'(st_exp));
    check("done_cycles", 64'(dn_got), 64'(dn_exp));
    check("done_low_after", 64'(done), 64'd0);
    check("hilo_after", {hi, lo}, {m_hi, m_lo});
  endtask

  // Start op, assert EX_Flush on cycle 'at' (start cycle = 1); nothing may be written.
  task automatic flush_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int at);
    @(negedge clk);
    ex_valid = 1'b1; op = o; opa = a; opb = b;
    repeat (at - 1) @(negedge clk);
    ex_flush = 1'b1;
    #1;
    check("stall_in_flush", 64'(stall), 64'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_flush = 1'b0; op = 3'd0;
    #1;
    check("stall_after_flush", 64'(stall), 64'd0);
    check("hilo_after_flush", {hi, lo}, {m_hi, m_lo});
  endtask

  // Monitor: every Done pulse retires the oldest queued expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL done_unexpected: got done pulse with HI:LO %h, required no pulse", {hi, lo});
        end else begin
          e = exp_q.pop_front();
          check("hilo_on_done", {hi, lo}, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    bit          rv;

    repeat (2) @(negedge clk);
    #1;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b1, 3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    issue(1'b1, 3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    issue(1'b1, 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    issue(1'b1, 3'd4, 32'd100, 32'd7, 1'b0);
    issue(1'b1, 3'd3, 32'd1234, 32'd0, 1'b0);
    issue(1'b1, 3'd5, 32'd5, 32'd0, 1'b0);
    issue(1'b1, 3'd6, 32'hA5A5_0001, 32'd0, 1'b0);
    issue(1'b1, 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    issue(1'b1, 3'd3, 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b0);
    issue(1'b1, 3'd3, 32'd100, 32'hFFFFFFF9, 1'b0);
    issue(1'b1, 3'd4, 32'hFFFFFFFF, 32'd1, 1'b0);
    issue(1'b1, 3'd3, 32'hFFFFFFF0, 32'd0, 1'b0);
    issue(1'b1, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    issue(1'b0, 3'd1, 32'd3, 32'd4, 1'b0);
    issue(1'b1, 3'd0, 32'd3, 32'd4, 1'b0);

    flush_op(3'd3, 32'd1000, 32'd3, 10);
    issue(1'b1, 3'd1, 32'd6, 32'd7, 1'b0);
    flush_op(3'd3, 32'd1000, 32'd3, 33);
    flush_op(3'd1, 32'd9, 32'd9, 3);
    flush_op(3'd1, 32'd9, 32'd9, 1);
    flush_op(3'd5, 32'd77, 32'd0, 1);
    issue(1'b1, 3'd4, 32'd1000, 32'd3, 1'b1);

    issue(1'b1, 3'd5, 32'd0, 32'd0, 1'b0);
    issue(1'b1, 3'd6, 32'd1, 32'd0, 1'b0);
    issue(1'b1, 3'd7, 32'd3, 32'hFFFFFFFF, 1'b0);

    for (int i = 0; i < 200; i++) begin
      ro = 3'($urandom_range(0, 7));
      rv = ($urandom_range(0, 9) != 0);
      ra = ($urandom_range(0, 15) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2, 3:    rb = 32'($urandom_range(1, 300));
        default: rb = 32'($urandom);
      endcase
      issue(rv, ro, ra, rb, 1'b1);
    end

    issue(1'b1, 3'd5, 32'h1111_2222, 32'd0, 1'b0);
    @(negedge clk);
    ex_valid = 1'b1; op = 3'd3; opa = 32'd12345; opb = 32'd7;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_div_hilo", {hi, lo}, 64'd0);
    check("rst_mid_div_stall", 64'(stall), 64'd0);
    check("rst_mid_div_done", 64'(done), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    ex_valid = 1'b0; op = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 3'd1, 32'hFFFFFFFD, 32'd5, 1'b0);

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage, owning the architectural HI/LO registers. Operands come from the EX-stage forwarding muxes, so they are already resolved against MEM/WB results. Multi-cycle ops raise a stall to the hazard/pipeline control until HI/LO are written. Single-cycle MTHI/MTLO writes are handled in the same block.

Parameters:
MUL_CYCLES, 2, cycles spent in MUL state before HI/LO write (1..4)
DIV_CYCLES, 32, divider iterations (one quotient bit per cycle; fixed for 32-bit operands)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
EX_valid  in  1  EX stage holds a live instruction
EX_MulDivOp  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 MADD (optional)
EX_Operand_A  in  32  forwarded rs value
EX_Operand_B  in  32  forwarded rt value
EX_Flush  in  1  kill EX-stage instruction this cycle
MulDiv_Stall  out  1  hold IF/ID/EX; combinational
HI  out  32  HI register
LO  out  32  LO register
MulDiv_Done  out  1  one-cycle pulse in DONE state

Behaviour:
- Reset (async, rst_n=0): state=IDLE, HI=0, LO=0, counter=0, operand/partial registers=0, MulDiv_Done=0.
- States: IDLE, MUL, DIV, DONE.
- start = EX_valid & ~EX_Flush & state==IDLE & op in {MULT, MULTU, DIV, DIVU, MADD}.
- MulDiv_Stall = start | state==MUL | state==DIV. It is 0 in DONE and 0 in IDLE without start.
- IDLE + start MULT/MULTU/MADD: latch operands -> MUL, counter=0.
- MUL: counter increments. When counter==MUL_CYCLES-1, write {HI,LO} from the 64-bit product and go to DONE.
  - Sign handling: signed for MULT/MADD, zero-extended for MULTU.
  - Total stall = MUL_CYCLES+1 cycles.
- IDLE + start DIV/DIVU with B!=0: latch |A|, |B| (signed) or raw values (unsigned), plus the sign bits -> DIV.
- DIV: one restoring-division step per cycle, 32 steps. On the last step:
  - LO = quotient; HI = remainder.
  - Signed fix-up: quotient negated if sign(A)^sign(B); remainder takes sign(A).
  - Then go to DONE. Total stall = 33 cycles.
- Divide by zero (B==0) at start: no DIV state. HI<=A, LO<=32'hFFFFFFFF at that edge, go to DONE. Stall=1 for one cycle.
- DONE: MulDiv_Done=1. Next edge goes to IDLE unconditionally. The EX instruction is still present but is NOT re-accepted, because DONE is not IDLE.
- MTHI/MTLO: in IDLE with EX_valid & ~EX_Flush, write HI or LO with Operand_A at the edge. No stall, no state change.
- Op 000, or EX_valid=0: no effect.
- EX_Flush in MUL/DIV: abort to IDLE next edge, HI/LO unchanged, stall drops combinationally that cycle.
- EX_Flush in IDLE: suppresses start and MTHI/MTLO.
- Operands are latched at start. Changes on EX_Operand_A/B during MUL/DIV are ignored.
- HI/LO outputs are the register values. New values are visible the cycle after the write edge (first DONE cycle).

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined: op 111 = MADD. Signed product is added to {HI,LO} as a 64-bit sum, written at the end of MUL; same timing as MULT.
- Undefined: op 111 is treated as none. No stall, no HI/LO change, no accumulator adder synthesized.

Test Plan:
- MULT, A=32'hFFFFFFFF, B=2 -> HI=FFFFFFFF, LO=FFFFFFFE; stall high exactly 3 cycles (MUL_CYCLES=2); Done pulse 1 cycle.
- MULTU, same operands -> HI=00000001, LO=FFFFFFFE.
- DIV, A=-7 (FFFFFFF9), B=2 -> LO=FFFFFFFD, HI=FFFFFFFF; stall 33 cycles. DIVU 100/7 -> LO=14 (0000000E), HI=2.
- DIV with B=0, A=1234 -> HI=000004D2, LO=FFFFFFFF; stall 1 cycle; then MTHI A=5 -> HI=5 next cycle, no stall.
- DIV started, EX_Flush asserted on cycle 10 -> state IDLE next edge, HI/LO keep prior values, stall low in the flush cycle.
- rst_n pulled low mid-DIV -> HI=LO=0 and stall=0 immediately. With MULDIV_MADD_EN and HI:LO=0:00000001, MADD 3*(-1) -> HI=FFFFFFFF, LO=FFFFFFFE.
